// File: rtl/mio_arbiter_pkg.sv
// mio_arb_pkg: shared encodings for the memory/IO port arbiter.
//   - FSM state encodings (IDLE, ACCESS, RESP)
//   - owner encodings, which also drive the grant_out debug output
//   - pick_owner(): arbitration between simultaneous requests
package mio_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam owner_t OWN_NONE = 2'b00;
    localparam owner_t OWN_CPU  = 2'b01;
    localparam owner_t OWN_DMA  = 2'b10;

    // Winner for this IDLE cycle. On a tie, round-robin gives the port to
    // whichever master did not own the previous transfer; cpu_prio forces
    // the CPU to win every tie.
    function automatic owner_t pick_owner(
        input logic   cpu_req,
        input logic   dma_req,
        input owner_t last_owner,
        input logic   cpu_prio
    );
        owner_t owner;
        owner = OWN_NONE;
        if (cpu_req && dma_req) begin
            owner = (cpu_prio || (last_owner != OWN_CPU)) ? OWN_CPU : OWN_DMA;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mio_arbiter_if.sv
// mio_arbiter_if: bundle of the CPU, DMA and memory-side signals around the
// arbiter.
//   slave  : arbiter's view (takes both requests, drives memory port)
//   master : environment's view (CPU, DMA engine and memory model)
//
// Handshake: a requester raises its request (CPU_MIO / dma_req) with we,
// addr and wdata stable and holds all of them until its one-cycle pulse
// (MIO_ready / dma_ack). Read data is valid only while the pulse is high.
// The request must be dropped in the cycle after the pulse, otherwise it is
// taken as a new transfer. There is no abort: once granted, a transfer
// always completes and always pulses.
interface mio_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU side
    logic              CPU_MIO;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              MIO_ready;
    // DMA side
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;
    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  CPU_MIO, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, MIO_ready,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output CPU_MIO, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, MIO_ready,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mio_arbiter_wait_cnt.sv
// mio_wait_cnt: loadable 4-bit down-counter for memory wait states.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one; holds at zero
//   count      : current value
//   zero       : count == 0
module mio_wait_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mio_arbiter.sv
// mio_arbiter: shares one memory/IO port between the multicycle CPU
// controller and a DMA/peripheral master. Each transfer is IDLE (arbitrate,
// latch) -> ACCESS for MEM_LAT cycles -> RESP (one-cycle ready/ack with
// registered read data) -> IDLE.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mio_arbiter_if.slave (CPU, DMA and memory signals)
//   grant_out  : current owner, 00 none / 01 CPU / 10 DMA
//   state_out  : FSM state (debug)
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..15 wait cycles per transfer).
// Build option: define MIO_ARBITER_CPU_PRIO_EN for fixed CPU priority on
// simultaneous requests; otherwise ties are resolved round-robin.
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    mio_arbiter_if.slave bus,
    output logic [1:0]   grant_out,
    output logic [1:0]   state_out
);

`ifdef MIO_ARBITER_CPU_PRIO_EN
    localparam logic CPU_PRIO = 1'b1;
`else
    localparam logic CPU_PRIO = 1'b0;
`endif

    // Counter starts at MEM_LAT-1 so that the zero cycle is the last of
    // MEM_LAT ACCESS cycles.
    localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

    logic [1:0]        state;
    owner_t            owner;
    owner_t            last_owner;
    owner_t            next_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              cnt_load;
    logic              cnt_en;
    logic [3:0]        cnt_val;
    logic              cnt_zero;
    logic              in_access;

    assign next_owner = pick_owner(bus.CPU_MIO, bus.dma_req, last_owner, CPU_PRIO);
    assign in_access  = (state == ST_ACCESS);
    assign cnt_load   = (state == ST_IDLE) && (next_owner != OWN_NONE);
    assign cnt_en     = in_access;

    mio_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .en       (cnt_en),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= OWN_NONE;
            last_owner  <= OWN_DMA;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (next_owner != OWN_NONE) begin
                        owner <= next_owner;
                        if (next_owner == OWN_CPU) begin
                            lat_we    <= bus.cpu_we;
                            lat_addr  <= bus.cpu_addr;
                            lat_wdata <= bus.cpu_wdata;
                        end else begin
                            lat_we    <= bus.dma_we;
                            lat_addr  <= bus.dma_addr;
                            lat_wdata <= bus.dma_wdata;
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        last_owner <= owner;
                        if (!lat_we) begin
                            if (owner == OWN_CPU) begin
                                cpu_rdata_q <= bus.mem_rdata;
                            end else begin
                                dma_rdata_q <= bus.mem_rdata;
                            end
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    owner <= OWN_NONE;
                    state <= ST_IDLE;
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port is quiet outside ACCESS; the write strobe fires only on
    // the final ACCESS cycle, so a reset earlier in ACCESS never commits.
    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && lat_we && cnt_zero;
    assign bus.mem_addr  = in_access ? lat_addr  : '0;
    assign bus.mem_wdata = in_access ? lat_wdata : '0;

    assign bus.MIO_ready = (state == ST_RESP) && (owner == OWN_CPU);
    assign bus.dma_ack   = (state == ST_RESP) && (owner == OWN_DMA);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;

    assign grant_out = owner;
    assign state_out = state;

endmodule
